seven_seg_arbiter: RTL

Shares the single `seven_seg_fsm` display between four requesters, e.g. score, timer, debug and status sources. Grants the display round-robin with a minimum dwell time per grant. Drives the registered `sixteen_bit_number` input of `seven_seg_fsm`. Requesters handshake with `req`/`grant`, and get a one-cycle `done` pulse when they lose the display.

---
 rtl/seven_seg_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/seven_seg_arbiter.sv
// Round-robin arbiter that shares one seven_seg_fsm display between four requesters,
// holding each grant for a minimum dwell time and tracking the granted value live.
module seven_seg_arbiter #(
    parameter int          DWELL_CYCLES = 100_000_000,
    parameter logic [15:0] IDLE_VALUE   = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [63:0] value,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic [15:0] sixteen_bit_number,
    output logic        display_valid
);

    localparam int            CW     = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(DWELL_CYCLES - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [1:0]    pointer;
    logic [1:0]    owner;

    logic [3:0]    candidates;
    logic          found;
    logic [1:0]    pick;
    logic          take_new;
    logic          go_idle;
    logic          end_grant;

    // First pending requester at or after the pointer; the current owner never competes with itself.
    always_comb begin
        candidates = req & ~grant;
        found      = 1'b0;
        pick       = pointer;
        for (int k = 3; k >= 0; k--) begin
            if (candidates[pointer + 2'(k)]) begin
                found = 1'b1;
                pick  = pointer + 2'(k);
            end
        end
    end

    // Decide whether this edge starts a new grant, ends the current one, or drops back to idle.
    always_comb begin
        take_new  = 1'b0;
        go_idle   = 1'b0;
        end_grant = 1'b0;
        case (state)
            IDLE: take_new = found;
            SHOW: begin
                if (!req[owner]) begin
                    end_grant = 1'b1;
                    take_new  = found;
                    go_idle   = !found;
                end else if (count == '0) begin
                    end_grant = found;
                    take_new  = found;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            grant              <= '0;
            done               <= '0;
            sixteen_bit_number <= IDLE_VALUE;
            display_valid      <= 1'b0;
            count              <= '0;
            pointer            <= '0;
            owner              <= '0;
        end else begin
            done <= end_grant ? (4'b0001 << owner) : 4'b0000;
            if (take_new) begin
                state              <= SHOW;
                grant              <= 4'b0001 << pick;
                sixteen_bit_number <= value[{pick, 4'b0000} +: 16];
                display_valid      <= 1'b1;
                count              <= RELOAD;
                pointer            <= pick + 2'd1;
                owner              <= pick;
            end else if (go_idle) begin
                state              <= IDLE;
                grant              <= '0;
                sixteen_bit_number <= IDLE_VALUE;
                display_valid      <= 1'b0;
                count              <= '0;
            end else if (state == SHOW) begin
                // Sole requester at expiry simply restarts its dwell.
                sixteen_bit_number <= value[{owner, 4'b0000} +: 16];
                count              <= (count == '0) ? RELOAD : count - 1'b1;
            end
        end
    end

endmodule
